// File: rtl/adc_share_arbiter.sv
// rtl/adc_share_arbiter.sv - round-robin sharing of one 12-bit serial ADC (optional ADC_AVG_EN: 4-frame averaging)
module adc_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CLK_DIV = 20,
  parameter int GAP_CYC = 2,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  input  logic               SDO,
  output logic               SCK,
  output logic               CS,
  output logic [11:0]        sample,
  output logic [ID_W-1:0]    sample_id,
  output logic               sample_valid,
  output logic               busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int GW = $clog2(GAP_CYC + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t          state;
  logic [CW-1:0]   div_cnt;
  logic            rise;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] winner;
  logic [3:0]      k;
  logic [11:0]     shreg;
  logic [GW-1:0]   gap_cnt;

`ifdef ADC_AVG_EN
  logic [13:0]     acc;
  logic [13:0]     acc_sum;
  logic [2:0]      frame;
  assign acc_sum = acc + {2'b00, shreg};
`endif

  // Every FSM action is aligned to the SCK rising edge.
  assign rise = (div_cnt == '0);

  // First requester at or after the pointer, searching upward with wrap.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [ID_W-1:0] p);
    logic [ID_W-1:0] w;
    logic            f;
    int              idx;
    w = '0;
    f = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(p) + i) % NUM_REQ;
      if (!f && r[idx]) begin
        w = ID_W'(idx);
        f = 1'b1;
      end
    end
    return w;
  endfunction

  assign winner = rr_pick(req, ptr);

  // Free-running SCK divider: high from count 0, low from count CLK_DIV/2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      SCK     <= 1'b0;
    end else begin
      if (div_cnt == CW'(CLK_DIV - 1)) div_cnt <= '0;
      else                              div_cnt <= div_cnt + 1'b1;
      if (rise)                              SCK <= 1'b1;
      else if (div_cnt == CW'(CLK_DIV / 2))  SCK <= 1'b0;
    end
  end

  // Arbitration, CS framing, SDO capture and result delivery.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= '0;
      cur_id       <= '0;
      grant        <= '0;
      CS           <= 1'b1;
      k            <= '0;
      shreg        <= '0;
      gap_cnt      <= '0;
      sample       <= '0;
      sample_id    <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
`ifdef ADC_AVG_EN
      acc          <= '0;
      frame        <= '0;
`endif
    end else begin
      sample_valid <= 1'b0;
      if (rise) begin
        case (state)
          IDLE: begin
            if (|req) begin
              grant  <= NUM_REQ'(1) << winner;
              cur_id <= winner;
              CS     <= 1'b0;
              k      <= '0;
              state  <= SHIFT;
              busy   <= 1'b1;
              ptr    <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
`ifdef ADC_AVG_EN
              acc    <= '0;
              frame  <= '0;
`endif
            end
          end
          SHIFT: begin
            k <= k + 1'b1;
            // Ticks 2..13 carry the 12 data bits, MSB first.
            if (k >= 4'd1 && k <= 4'd12) shreg <= {shreg[10:0], SDO};
            if (k == 4'd13) begin
              CS      <= 1'b1;
              state   <= GAP;
              gap_cnt <= '0;
`ifdef ADC_AVG_EN
              acc   <= acc_sum;
              frame <= frame + 1'b1;
              if (frame == 3'd3) begin
                grant        <= '0;
                sample       <= acc_sum[13:2];
                sample_id    <= cur_id;
                sample_valid <= 1'b1;
              end
`else
              grant        <= '0;
              sample       <= shreg;
              sample_id    <= cur_id;
              sample_valid <= 1'b1;
`endif
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt + 1'b1;
`ifdef ADC_AVG_EN
            // Between averaged frames, one extra tick replaces the IDLE arbitration tick.
            if (frame != 3'd4) begin
              if (gap_cnt == GW'(GAP_CYC)) begin
                CS    <= 1'b0;
                k     <= '0;
                state <= SHIFT;
              end
            end else if (gap_cnt == GW'(GAP_CYC - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
`else
            if (gap_cnt == GW'(GAP_CYC - 1)) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
`endif
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/adc_share_arbiter.md
Name: adc_share_arbiter

Overview:
Shares one LTC2315-style 12-bit serial ADC among NUM_REQ requesters. It owns the divided SCK, the CS framing and SDO capture. It arbitrates requests round-robin and returns each 12-bit result tagged with the requester index. It sits between the ADC GPIO pins and the capture/twinning logic that previously drove the ADC directly.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CLK_DIV, 20, clk cycles per SCK period; even, >=4 (50 MHz -> 2.5 MHz)
GAP_CYC, 2, SCK periods CS stays high after a frame before IDLE (>=1)
ID_W, 2, width of sample_id; must be >= clog2(NUM_REQ)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous, active-low reset
req  in  NUM_REQ  level request per requester
grant  out  NUM_REQ  one-hot, held for the whole frame of the granted requester
SDO  in  1  ADC serial data
SCK  out  1  ADC serial clock, 50% duty
CS  out  1  ADC chip select, active low
sample  out  12  last completed conversion, MSB first assembled
sample_id  out  ID_W  index of requester owning sample
sample_valid  out  1  one-clk pulse when sample/sample_id update
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (rst==0 at a clk edge):
  - div counter=0, SCK=0, CS=1, grant=0, sample=0, sample_id=0, sample_valid=0, busy=0.
  - FSM=IDLE; round-robin pointer set so req[0] has highest priority.
  - Reset mid-frame aborts the frame silently: no sample_valid.
- Divider: counter runs 0..CLK_DIV-1 and wraps.
  - Rise tick = cycle with counter==0; SCK<=1.
  - counter==CLK_DIV/2 -> SCK<=0.
  - SCK runs continuously out of reset. All FSM actions below happen only on rise ticks.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - CS=1, grant=0.
  - On a rise tick with req!=0: winner = first set bit at or after pointer, searching upward with wrap.
  - Actions: grant<=onehot(winner), CS<=0, k<=0, state<=SHIFT, pointer<=winner+1 mod NUM_REQ.
- SHIFT: k increments on each rise tick (k=0 is the CS-low tick).
  - k=1: no capture.
  - k=2..13: shift reg <= {shift[10:0],SDO}.
  - k=14: CS<=1, grant<=0, state<=GAP.
    - sample<=shift reg, sample_id<=winner, sample_valid<=1 on the same edge.
    - sample_valid clears on the next clk.
  - Deasserting req mid-frame does not abort; the result is still delivered.
- GAP:
  - CS=1; counts GAP_CYC rise ticks and returns to IDLE on the GAP_CYC-th one.
  - IDLE arbitrates from the next rise tick.
  - Back-to-back frame starts are therefore 15+GAP_CYC SCK periods apart (default 17 x 20 = 340 clk).
- Outputs:
  - CS low spans exactly 14 SCK periods per frame.
  - sample and sample_id hold between valids.
  - busy = (state!=IDLE).
- Simultaneous events: a req rising in the same cycle as a rise tick in IDLE is seen. Requests arriving during SHIFT/GAP wait.

Optional Feature:
ADC_AVG_EN
- Defined: each grant runs 4 consecutive frames (normal GAP between them). grant is held high across all 4 frames and gaps. Conversions are summed in a 14-bit accumulator. Only after the 4th frame: sample<=acc[13:2] (truncate), sample_valid pulses once. busy stays high throughout. Reset clears the accumulator.
- Undefined: one frame per grant as above; no accumulator logic is synthesized.

Test Plan:
- No req after reset -> SCK toggles 10 high/10 low clk, CS=1, busy=0, grant=0, no sample_valid over 1000 clk.
- Only req[1] held; ADC model drives 0xA5C on k=2..13 -> grant=4'b0010 for 14 SCK periods; sample=0xA5C, sample_id=1; one sample_valid pulse; next start 340 clk after the first.
- req=4'b1111 held -> grant order 0,1,2,3,0 with starts 340 clk apart; model values 0x001,0x002,0x003,0x004 returned with matching ids.
- req[2] only, dropped at k=5 -> frame completes; sample_valid with id=2; FSM then idles (busy=0 after GAP).
- rst=0 for 3 clk at k=7 with req[3] set -> CS=1, SCK=0, grant=0 on the reset edge; no sample_valid. After release with req=4'b1001, the first grant goes to req[0].
- ADC_AVG_EN defined; req[0] only; model returns 0x100,0x101,0x102,0x103 -> grant held for all 4 frames; a single valid with sample=0x101, id=0.
